alu_multiciclo: RTL
===================

# alu_multiciclo

Parametrised, multi-cycle ALU that replaces the purely combinational ALU in the execute stage of the fetch/execute datapath. It accepts a request on a start/busy handshake and registers the operands. It completes single-cycle operations in one cycle, and completes variable-distance shifts and shift-add multiplication iteratively over several cycles. It returns a registered result with status flags and a one-cycle completion pulse to the control unit.

## Interface
- ANCHO, 32: operand/result width in bits; ≥ 4, power of two.
- S, $clog2(ANCHO): derived, not overridable. Width of the shift distance n = b[S-1:0].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- inicio  in  1  request strobe; sampled only while ocupado=0.
- a  in  ANCHO  operand A; sampled at the accept edge.
- b  in  ANCHO  operand B; sampled at the accept edge.
- operador  in  4  operation code; sampled at the accept edge.
- resultado  out  ANCHO  registered result; holds until the next completion.
- cero  out  1  resultado == 0; updated with resultado.
- acarreo  out  1  carry/borrow/shifted-out bit; updated with resultado.
- desbordamiento  out  1  overflow; updated with resultado.
- error  out  1  invalid operador on the last completed operation.
- ocupado  out  1  operation in progress; new requests are ignored.
- listo  out  1  one-cycle pulse: outputs just updated.

## Operation
- Operation codes:
  - 0: add.
  - 1: and.
  - 2: eq; result is 1/0.
  - 3: unsigned gt; result is 1/0.
  - 4: shl by n.
  - 5: logical shr by n.
  - 6: sub (a−b).
  - 7: mul; low ANCHO bits of a·b.
  - 8: or.
  - 9: xor.
  - 10: arithmetic shr by n.
  - 11: signed lt; result is 1/0.
  - 12–15: invalid.
- FSM states: INACTIVO, CALCULO.
  - INACTIVO & inicio: latch a, b, operador and n into internal registers; go to CALCULO; ocupado←1.
  - CALCULO: run the operation. On the final cycle, write resultado and flags, listo←1, ocupado←0, go to INACTIVO.
- Latency L, counted in edges after the accept edge E0. Outputs and listo are written at edge E_L.
  - Codes 0–3, 6, 8, 9, 11 and invalid codes: L=1.
  - Shifts (4, 5, 10): L=n+1. One bit per edge at E1..En; E_{n+1} commits. For n=0, L=1 and resultado=a. Bits of b above S are ignored.
  - Mul (7): L=ANCHO+1. ANCHO shift-add iterations on a 2·ANCHO accumulator, then commit.
- Flags, committed with resultado:
  - add: acarreo = carry out; desbordamiento = signed overflow.
  - sub: acarreo = borrow (a<b unsigned); desbordamiento = signed overflow.
  - shifts: acarreo = last bit shifted out, 0 if n=0; desbordamiento=0.
  - mul: desbordamiento = upper ANCHO bits of the product ≠ 0; acarreo=0.
  - All other operations: acarreo=0, desbordamiento=0.
  - cero always reflects the committed resultado.
- Invalid code: resultado=0, cero=1, acarreo=0, desbordamiento=0, error=1, L=1. Any valid completion clears error.
- inicio while ocupado=1 is ignored entirely: no queueing and no effect on the running operation.
- Changes to a, b or operador after E0 have no effect on the running operation.

## Timing
- Reset values: resultado=0, cero=0, acarreo=0, desbordamiento=0, error=0, ocupado=0, listo=0; state INACTIVO.
- rst has priority over every input, including inicio in the same cycle.
- rst in mid-operation aborts the operation: no listo, outputs return to reset values.
- ocupado rises at E0 and falls at E_L, the same edge at which listo rises.
- listo is high for exactly one cycle.
- Back-to-back: inicio held high in the listo cycle is accepted at that cycle's closing edge. Sustained throughput for single-cycle operations is one result every 2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Add overflow: add, a=0xFFFFFFFF, b=1 -> at E1 resultado=0, cero=1, acarreo=1, desbordamiento=0, listo one cycle, ocupado high for E0..E1 only.
- Signed sub overflow: sub, a=0x80000000, b=1 -> resultado=0x7FFFFFFF, desbordamiento=1, acarreo=0. Then sub, a=3, b=5 -> resultado=0xFFFFFFFE, acarreo=1.
- Shift distances: shl, a=1, b=5 -> resultado=0x20, listo exactly at E6. Arithmetic shr, a=0x80000001, b=0x21 (n=1) -> resultado=0xC0000000, acarreo=1, L=2. shl with b=0 -> resultado=a, L=1.
- Multiply: a=0x00010000, b=0x00010000 -> resultado=0, cero=1, desbordamiento=1, listo at E33. a=7, b=6 -> resultado=42, desbordamiento=0.
- Handshake: pulse inicio during a mul -> ignored; result and timing unchanged. Hold inicio in the listo cycle with a new add -> accepted, listo again 2 cycles later.
- Reset and invalid code: assert rst at E10 of a mul -> no listo, all outputs 0, ocupado=0 at the next edge. operador=13 -> resultado=0, error=1, L=1. A following valid add clears error.

Source files
------------

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU for the execute stage: start/busy handshake, registered
// operands, single-cycle logic/arith ops, iterative shifts and shift-add mul.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// INACTIVO | idle, waiting for inicio; outputs hold the last committed result
// CALCULO  | operation running; counter == 0 means this edge commits
module alu_multiciclo #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic [3:0]       operador,
  output logic [ANCHO-1:0] resultado,
  output logic             cero,
  output logic             acarreo,
  output logic             desbordamiento,
  output logic             error,
  output logic             ocupado,
  output logic             listo
);
  localparam int S = $clog2(ANCHO);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_EQ  = 4'd2;
  localparam logic [3:0] OP_GT  = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_XOR = 4'd9;
  localparam logic [3:0] OP_SAR = 4'd10;
  localparam logic [3:0] OP_LT  = 4'd11;

  typedef enum logic {INACTIVO, CALCULO} estado_t;

  estado_t              estado, estado_sig;
  // For shifts, a_r is the working register shifted in place.
  logic [ANCHO-1:0]     a_r, a_sig, b_r, b_sig;
  logic [3:0]           op_r, op_sig;
  logic [S:0]           cnt, cnt_sig;
  logic [2*ANCHO-1:0]   acc, acc_sig;
  logic                 cy, cy_sig;
  logic [ANCHO-1:0]     res_sig;
  logic                 cero_sig, acarreo_sig, desb_sig, error_sig, listo_sig;
  logic [ANCHO:0]       suma;
  logic [ANCHO-1:0]     resta;
  logic [ANCHO:0]       mul_parcial;
  logic                 es_despl;

  assign suma        = {1'b0, a_r} + {1'b0, b_r};
  assign resta       = a_r - b_r;
  assign mul_parcial = {1'b0, acc[2*ANCHO-1:ANCHO]} + (acc[0] ? {1'b0, a_r} : '0);
  assign es_despl    = (operador == OP_SHL) || (operador == OP_SHR) || (operador == OP_SAR);
  assign ocupado     = (estado == CALCULO);

  // State, operand and output registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado         <= INACTIVO;
      a_r            <= '0;
      b_r            <= '0;
      op_r           <= '0;
      cnt            <= '0;
      acc            <= '0;
      cy             <= 1'b0;
      resultado      <= '0;
      cero           <= 1'b0;
      acarreo        <= 1'b0;
      desbordamiento <= 1'b0;
      error          <= 1'b0;
      listo          <= 1'b0;
    end else begin
      estado         <= estado_sig;
      a_r            <= a_sig;
      b_r            <= b_sig;
      op_r           <= op_sig;
      cnt            <= cnt_sig;
      acc            <= acc_sig;
      cy             <= cy_sig;
      resultado      <= res_sig;
      cero           <= cero_sig;
      acarreo        <= acarreo_sig;
      desbordamiento <= desb_sig;
      error          <= error_sig;
      listo          <= listo_sig;
    end
  end

  // Next-state: accept, iterate while the counter runs, commit when it hits zero.
  always_comb begin
    estado_sig  = estado;
    a_sig       = a_r;
    b_sig       = b_r;
    op_sig      = op_r;
    cnt_sig     = cnt;
    acc_sig     = acc;
    cy_sig      = cy;
    res_sig     = resultado;
    cero_sig    = cero;
    acarreo_sig = acarreo;
    desb_sig    = desbordamiento;
    error_sig   = error;
    listo_sig   = 1'b0;
    case (estado)
      INACTIVO: begin
        if (inicio) begin
          estado_sig = CALCULO;
          a_sig      = a;
          b_sig      = b;
          op_sig     = operador;
          cy_sig     = 1'b0;
          acc_sig    = {{ANCHO{1'b0}}, b};
          if (operador == OP_MUL)  cnt_sig = (S+1)'(ANCHO);
          else if (es_despl)       cnt_sig = {1'b0, b[S-1:0]};
          else                     cnt_sig = '0;
        end
      end
      CALCULO: begin
        if (cnt != '0) begin
          cnt_sig = cnt - (S+1)'(1);
          case (op_r)
            OP_SHL: begin cy_sig = a_r[ANCHO-1]; a_sig = {a_r[ANCHO-2:0], 1'b0}; end
            OP_SHR: begin cy_sig = a_r[0];       a_sig = {1'b0, a_r[ANCHO-1:1]}; end
            OP_SAR: begin cy_sig = a_r[0];       a_sig = {a_r[ANCHO-1], a_r[ANCHO-1:1]}; end
            default: acc_sig = {mul_parcial, acc[ANCHO-1:1]};
          endcase
        end else begin
          estado_sig  = INACTIVO;
          listo_sig   = 1'b1;
          acarreo_sig = 1'b0;
          desb_sig    = 1'b0;
          error_sig   = 1'b0;
          case (op_r)
            OP_ADD: begin
              res_sig     = suma[ANCHO-1:0];
              acarreo_sig = suma[ANCHO];
              desb_sig    = (a_r[ANCHO-1] == b_r[ANCHO-1]) && (suma[ANCHO-1] != a_r[ANCHO-1]);
            end
            OP_SUB: begin
              res_sig     = resta;
              acarreo_sig = (a_r < b_r);
              desb_sig    = (a_r[ANCHO-1] != b_r[ANCHO-1]) && (resta[ANCHO-1] != a_r[ANCHO-1]);
            end
            OP_AND: res_sig = a_r & b_r;
            OP_OR:  res_sig = a_r | b_r;
            OP_XOR: res_sig = a_r ^ b_r;
            OP_EQ:  res_sig = {{(ANCHO-1){1'b0}}, (a_r == b_r)};
            OP_GT:  res_sig = {{(ANCHO-1){1'b0}}, (a_r > b_r)};
            OP_LT:  res_sig = {{(ANCHO-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
            OP_SHL, OP_SHR, OP_SAR: begin
              res_sig     = a_r;
              acarreo_sig = cy;
            end
            OP_MUL: begin
              res_sig  = acc[ANCHO-1:0];
              desb_sig = |acc[2*ANCHO-1:ANCHO];
            end
            default: begin
              res_sig   = '0;
              error_sig = 1'b1;
            end
          endcase
          cero_sig = (res_sig == '0);
        end
      end
      default: estado_sig = INACTIVO;
    endcase
  end
endmodule
